// File: rtl/dmem_responder.sv
// Memory-side responder for a valid/ready load/store port: one aligned 64-bit
// request at a time, serviced from a doubleword array after LATENCY cycles.
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  logic                 acc_en;
  logic                 acc_write;
  logic                 acc_err;
  logic                 mem_we;
  logic [63:0]          acc_addr;
  logic [63:0]          acc_wdata;
  logic [ADDR_BITS-1:0] acc_idx;

  assign req_ready  = (state_q == IDLE) && !resetl;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With LATENCY=1 the access happens on the accepting edge, so it must use
  // the live request rather than the (not yet written) latched copy.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_idx = acc_addr[ADDR_BITS+2:3];
    acc_err = (acc_addr[2:0] != 3'b000) || (acc_addr[63:ADDR_BITS+3] != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            acc_en  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          acc_en  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (acc_en) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? '0 : mem[acc_idx];
    end

    mem_we = acc_en && acc_write && !acc_err && !resetl;
  end

  always_ff @(posedge clk) begin
    if (resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset: contents survive resetl.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=3 instance for most scenarios,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        resetl;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [63:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [63:0] b_resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [63:0] x_rd;
  logic        x_er;
  int          x_lat;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
    .clk(clk), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .resetl(resetl),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Issue one request from idle (called at a negedge); lat = edges from
  // acceptance to resp_valid, -1 on timeout. Returns at a negedge, idle.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    x_lat = -1; x_rd = '0; x_er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (resp_valid) begin
        x_lat = k; x_rd = resp_rdata; x_er = resp_err;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetl = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    total++; if (resp_rdata !== 64'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    resetl = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_b_req_ready got=%b want=1", b_req_ready); end
  endtask

  task automatic test_store_load();
    xact(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
    total++; if (x_lat !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", x_lat); end
    total++; if (x_er !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", x_er); end
    total++; if (x_rd !== 64'h0) begin bad++; $display("FAIL store_rdata got=%h want=0", x_rd); end
    xact(1'b0, 64'h40, 64'h0);
    total++; if (x_lat !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", x_lat); end
    total++; if (x_er !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", x_er); end
    total++; if (x_rd !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL load_rdata got=%h want=deadbeefcafef00d", x_rd); end
  endtask

  task automatic test_errors();
    xact(1'b0, 64'h43, 64'h0);
    total++; if (x_er !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", x_er); end
    total++; if (x_rd !== 64'h0) begin bad++; $display("FAIL misalign_rdata got=%h want=0", x_rd); end
    xact(1'b0, 64'h800, 64'h0);
    total++; if (x_er !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", x_er); end
    total++; if (x_rd !== 64'h0) begin bad++; $display("FAIL range_rdata got=%h want=0", x_rd); end
    // erroring stores must not touch the array (0x41 would alias index 8)
    xact(1'b1, 64'h41, 64'h5555_5555_5555_5555);
    total++; if (x_er !== 1'b1) begin bad++; $display("FAIL bad_store_err got=%b want=1", x_er); end
    xact(1'b1, 64'h7F8, 64'h01234567_89ABCDEF);
    total++; if (x_er !== 1'b0) begin bad++; $display("FAIL top_store_err got=%b want=0", x_er); end
    xact(1'b0, 64'h7F8, 64'h0);
    total++; if (x_er !== 1'b0) begin bad++; $display("FAIL top_load_err got=%b want=0", x_er); end
    total++; if (x_rd !== 64'h01234567_89ABCDEF) begin bad++; $display("FAIL top_load_rdata got=%h want=0123456789abcdef", x_rd); end
    xact(1'b0, 64'h40, 64'h0);
    total++; if (x_rd !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL bad_store_untouched got=%h want=deadbeefcafef00d", x_rd); end
  endtask

  task automatic test_backpressure();
    int lat;
    req_write = 1'b0; req_addr = 64'h40; req_wdata = '0; req_valid = 1'b1;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 64'h7F8;
    for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_valid_rise got=%b want=1", resp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, resp_valid); end
      total++; if (resp_rdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL bp_hold_rdata[%0d] got=%h want=deadbeefcafef00d", i, resp_rdata); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL bp_hold_err[%0d] got=%b want=0", i, resp_err); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_req_ready[%0d] got=%b want=0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_after_hs_req_ready got=%b want=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_held_accept got=%b want=0", req_ready); end
    lat = -1;
    for (int k = 1; k < 20; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_second_resp_edge got=%0d want=4", lat); end
    total++; if (resp_rdata !== 64'h01234567_89ABCDEF) begin bad++; $display("FAIL bp_second_rdata got=%h want=0123456789abcdef", resp_rdata); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [4];
    logic [63:0] data  [4];
    logic [63:0] got   [4];
    logic        gerr  [4];
    int          acc   [4];
    int idx, nresp, cyc;
    addrs[0] = 64'h0;   data[0] = 64'hA0A0_0000_0000_0001;
    addrs[1] = 64'h8;   data[1] = 64'hB1B1_0000_0000_0002;
    addrs[2] = 64'h10;  data[2] = 64'hC2C2_0000_0000_0003;
    addrs[3] = 64'h7F8; data[3] = 64'hD3D3_0000_0000_0004;
    for (int pass = 0; pass < 2; pass++) begin
      idx = 0; nresp = 0; cyc = 0;
      b_req_write = (pass == 0);
      while (nresp < 4 && cyc < 40) begin
        if (idx < 4) begin
          b_req_valid = 1'b1; b_req_addr = addrs[idx]; b_req_wdata = data[idx];
          if (b_req_ready) begin acc[idx] = cyc; idx++; end
        end else begin
          b_req_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
        if (b_resp_valid) begin got[nresp] = b_resp_rdata; gerr[nresp] = b_resp_err; nresp++; end
      end
      b_req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (nresp !== 4) begin bad++; $display("FAIL b2b_resp_count pass=%0d got=%0d want=4", pass, nresp); end
      for (int i = 0; i < nresp; i++) begin
        total++;
        if (got[i] !== ((pass == 0) ? 64'h0 : data[i])) begin
          bad++; $display("FAIL b2b_rdata pass=%0d[%0d] got=%h want=%h", pass, i, got[i], (pass == 0) ? 64'h0 : data[i]);
        end
        total++; if (gerr[i] !== 1'b0) begin bad++; $display("FAIL b2b_err pass=%0d[%0d] got=%b want=0", pass, i, gerr[i]); end
      end
      for (int i = 1; i < idx; i++) begin
        total++;
        if (acc[i] - acc[i-1] !== 2) begin
          bad++; $display("FAIL b2b_spacing pass=%0d[%0d] got=%0d want=2", pass, i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    xact(1'b1, 64'h10, 64'h2222);
    total++; if (x_er !== 1'b0) begin bad++; $display("FAIL mw_setup_err got=%b want=0", x_er); end
    req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h1111; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    resetl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mw_req_ready[%0d] got=%b want=0", i, req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mw_resp_valid[%0d] got=%b want=0", i, resp_valid); end
    end
    resetl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mw_no_resp[%0d] got=%b want=0", i, resp_valid); end
    end
    xact(1'b0, 64'h10, 64'h0);
    total++; if (x_rd !== 64'h2222) begin bad++; $display("FAIL mw_store_dropped got=%h want=2222", x_rd); end
  endtask

  initial begin
    resetl = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
